// File: rtl/ia_sparse_packer.sv
// rtl/ia_sparse_packer.sv - requantize, ReLU and compact one pixel's channel vector into a sparse IA bundle
// Optional feature macro PACKER_RELU_EN: when defined, negative results clamp to zero instead of packing.
module ia_sparse_packer #(
  parameter int CHANNEL = 32,
  parameter int ACC_W   = 36,
  parameter int DATA_W  = 16,
  parameter int C_W     = 5,
  parameter int LANES   = 4,
  parameter int HW_W    = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [HW_W-1:0]          i_h,
  input  logic [HW_W-1:0]          i_w,
  input  logic signed [ACC_W-1:0]  i_acc [0:CHANNEL-1],
  input  logic [5:0]               i_shift,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [HW_W-1:0]          o_ia_h,
  output logic [HW_W-1:0]          o_ia_w,
  output logic signed [DATA_W-1:0] o_ia_data [0:CHANNEL-1],
  output logic [C_W-1:0]           o_ia_c_idx [0:CHANNEL-1],
  output logic [$clog2(CHANNEL):0] o_ia_len
);
  localparam int LEN_W = $clog2(CHANNEL) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         ch_cnt_q, ch_cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [5:0]               shift_q, shift_d;
  logic [HW_W-1:0]          h_q, h_d, w_q, w_d;
  logic signed [ACC_W-1:0]  acc_q [0:CHANNEL-1];
  logic signed [ACC_W-1:0]  acc_d [0:CHANNEL-1];
  logic signed [DATA_W-1:0] data_q [0:CHANNEL-1];
  logic signed [DATA_W-1:0] data_d [0:CHANNEL-1];
  logic [C_W-1:0]           idx_q [0:CHANNEL-1];
  logic [C_W-1:0]           idx_d [0:CHANNEL-1];
  logic                     valid_q, valid_d, ready_q, ready_d;
  logic [LEN_W-1:0]         slot;

  logic signed [ACC_W-1:0]  lane_q   [LANES];
  logic signed [DATA_W-1:0] lane_val [LANES];
  logic                     lane_nz  [LANES];
  logic [C_W-1:0]           lane_ch  [LANES];

  // Per-lane requantization of the current channel group
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_ch[l] = C_W'(ch_cnt_q + LEN_W'(l));
      lane_q[l]  = acc_q[lane_ch[l]] >>> shift_q;
`ifdef PACKER_RELU_EN
      if (lane_q[l][ACC_W-1]) lane_val[l] = '0;
`else
      if (lane_q[l] < SAT_MIN) lane_val[l] = SAT_MIN[DATA_W-1:0];
`endif
      else if (lane_q[l] > SAT_MAX) lane_val[l] = SAT_MAX[DATA_W-1:0];
      else lane_val[l] = lane_q[l][DATA_W-1:0];
      lane_nz[l] = (lane_val[l] != '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    len_d    = len_q;
    shift_d  = shift_q;
    h_d      = h_q;
    w_d      = w_q;
    acc_d    = acc_q;
    data_d   = data_q;
    idx_d    = idx_q;
    slot     = len_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          acc_d    = i_acc;
          shift_d  = i_shift;
          h_d      = i_h;
          w_d      = i_w;
          len_d    = '0;
          ch_cnt_d = '0;
          for (int c = 0; c < CHANNEL; c++) begin
            data_d[c] = '0;
            idx_d[c]  = '0;
          end
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Survivors land in consecutive slots, so lower lanes claim lower slots
        for (int l = 0; l < LANES; l++) begin
          if (lane_nz[l]) begin
            data_d[slot[C_W-1:0]] = lane_val[l];
            idx_d[slot[C_W-1:0]]  = lane_ch[l];
            slot = slot + LEN_W'(1);
          end
        end
        len_d = slot;
        if (ch_cnt_q == LEN_W'(CHANNEL - LANES)) begin
          ch_cnt_d = '0;
          state_d  = S_OUT;
        end else begin
          ch_cnt_d = ch_cnt_q + LEN_W'(LANES);
        end
      end
      S_OUT: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_OUT);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ch_cnt_q <= '0;
      len_q    <= '0;
      shift_q  <= '0;
      h_q      <= '0;
      w_q      <= '0;
      acc_q    <= '{default: '0};
      data_q   <= '{default: '0};
      idx_q    <= '{default: '0};
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
      len_q    <= len_d;
      shift_q  <= shift_d;
      h_q      <= h_d;
      w_q      <= w_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_ready    = ready_q;
  assign o_ia_h     = h_q;
  assign o_ia_w     = w_q;
  assign o_ia_len   = len_q;
  assign o_ia_data  = data_q;
  assign o_ia_c_idx = idx_q;

endmodule

// File: tb/tb_ia_sparse_packer.sv
// tb/tb_ia_sparse_packer.sv - directed table plus randomized pixels against a channel-by-channel reference model
module tb_ia_sparse_packer;
  localparam int CHANNEL = 32;
  localparam int ACC_W   = 36;
  localparam int DATA_W  = 16;
  localparam int C_W     = 5;
  localparam int LANES   = 4;
  localparam int HW_W    = 6;
  localparam int SCAN    = CHANNEL / LANES;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic                     i_valid = 1'b0;
  logic                     i_ready = 1'b0;
  logic                     o_ready, o_valid;
  logic [HW_W-1:0]          i_h = '0, i_w = '0, o_ia_h, o_ia_w;
  logic signed [ACC_W-1:0]  i_acc [0:CHANNEL-1];
  logic [5:0]               i_shift = '0;
  logic signed [DATA_W-1:0] o_ia_data [0:CHANNEL-1];
  logic [C_W-1:0]           o_ia_c_idx [0:CHANNEL-1];
  logic [$clog2(CHANNEL):0] o_ia_len;

  ia_sparse_packer #(
    .CHANNEL(CHANNEL), .ACC_W(ACC_W), .DATA_W(DATA_W), .C_W(C_W), .LANES(LANES), .HW_W(HW_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_h(i_h), .i_w(i_w), .i_acc(i_acc), .i_shift(i_shift),
    .o_valid(o_valid), .i_ready(i_ready), .o_ia_h(o_ia_h), .o_ia_w(o_ia_w),
    .o_ia_data(o_ia_data), .o_ia_c_idx(o_ia_c_idx), .o_ia_len(o_ia_len)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cycnt = 0;
  always @(posedge i_clk) cycnt <= cycnt + 1;

  logic signed [ACC_W-1:0] acc_in [CHANNEL];
  int              shift_in;
  logic [HW_W-1:0] h_in, w_in;
  longint          exp_data [CHANNEL];
  int              exp_idx [CHANNEL];
  int              exp_len;
  logic [HW_W-1:0] exp_h, exp_w;
  int              acc_cyc, prev_cyc, hs_cyc;

  typedef struct {
    int kind; int shift; int h; int w;
    int exp_len; int exp_d0; int exp_c0; int exp_d1; int exp_c1;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every channel handled independently, survivors appended in channel order
  task automatic model();
    longint a, q;
    exp_len = 0;
    for (int c = 0; c < CHANNEL; c++) begin
      exp_data[c] = 0;
      exp_idx[c]  = 0;
    end
    for (int c = 0; c < CHANNEL; c++) begin
      a = acc_in[c];
      q = a >>> shift_in;
`ifdef PACKER_RELU_EN
      if (q < 0) q = 0;
`endif
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      if (q != 0) begin
        exp_data[exp_len] = q;
        exp_idx[exp_len]  = c;
        exp_len++;
      end
    end
    exp_h = h_in;
    exp_w = w_in;
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < CHANNEL; c++) i_acc[c] = acc_in[c];
    i_shift = 6'(shift_in);
    i_h = h_in;
    i_w = w_in;
  endtask

  task automatic build(input int kind);
    for (int c = 0; c < CHANNEL; c++) acc_in[c] = '0;
    case (kind)
      0: begin acc_in[3] = 36'sh100; acc_in[17] = 36'sh40; end
      1: for (int c = 0; c < CHANNEL; c++) acc_in[c] = 36'(c + 1);
      3: begin acc_in[0] = 36'sh4_0000_0000; acc_in[1] = -36'sd8; end
      4: begin acc_in[5] = 36'sh7_FFFF_FFFF; acc_in[6] = -36'sd1; end
      default: ;
    endcase
  endtask

  task automatic rand_pixel();
    bit all_zero;
    all_zero = ($urandom_range(0, 7) == 0);
    for (int c = 0; c < CHANNEL; c++) begin
      case (all_zero ? 0 : $urandom_range(0, 3))
        0, 1: acc_in[c] = '0;
        2: acc_in[c] = 36'($urandom_range(0, 400)) - 36'sd200;
        default: acc_in[c] = 36'({$urandom, $urandom});
      endcase
    end
    shift_in = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
    h_in = 6'($urandom);
    w_in = 6'($urandom);
  endtask

  task automatic accept();
    int n = 0;
    drive_inputs();
    i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
    if (n >= 100) check("accept_timeout", n, 0);
    model();
    @(posedge i_clk); #1;
    acc_cyc = cycnt;
    i_valid = 1'b0;
    for (int c = 0; c < CHANNEL; c++) i_acc[c] = 36'({$urandom, $urandom});
    i_shift = 6'($urandom);
    i_h = 6'($urandom);
  endtask

  task automatic wait_valid(input bit noise);
    int lat = 0;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
      if (!o_valid && noise) i_ready = 1'($urandom);
    end
    i_ready = 1'b0;
    check("latency", lat, SCAN);
  endtask

  task automatic check_bundle();
    int bad = 0;
    int first = -1;
    check("len", o_ia_len, exp_len);
    check("h", o_ia_h, exp_h);
    check("w", o_ia_w, exp_w);
    for (int k = 0; k < CHANNEL; k++) begin
      if (longint'(o_ia_data[k]) != exp_data[k] || int'(o_ia_c_idx[k]) != exp_idx[k]) begin
        if (first < 0) first = k;
        bad++;
      end
    end
    if (bad != 0)
      $display("  first bad slot %0d: data %0d idx %0d want data %0d idx %0d",
               first, o_ia_data[first], o_ia_c_idx[first], exp_data[first], exp_idx[first]);
    check("slot_mismatches", bad, 0);
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    hs_cyc = cycnt;
    check("valid_drop", o_valid, 0);
    check("ready_back", o_ready, 1);
  endtask

  task automatic collect(input int stall, input bit noise);
    wait_valid(noise);
    for (int s = 0; s < stall; s++) begin
      @(posedge i_clk); #1;
      check("stall_valid", o_valid, 1);
    end
    check_bundle();
    handshake();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nz;
    bit saw;
    for (int c = 0; c < CHANNEL; c++) i_acc[c] = '0;

    vecs[0] = '{kind:0, shift:4, h:2, w:5, exp_len:2, exp_d0:16, exp_c0:3, exp_d1:4, exp_c1:17};
    vecs[1] = '{kind:1, shift:0, h:7, w:9, exp_len:32, exp_d0:1, exp_c0:0, exp_d1:2, exp_c1:1};
    vecs[2] = '{kind:2, shift:3, h:63, w:0, exp_len:0, exp_d0:0, exp_c0:0, exp_d1:0, exp_c1:0};
`ifdef PACKER_RELU_EN
    vecs[3] = '{kind:3, shift:2, h:1, w:1, exp_len:1, exp_d0:32767, exp_c0:0, exp_d1:0, exp_c1:0};
    vecs[4] = '{kind:4, shift:40, h:3, w:4, exp_len:0, exp_d0:0, exp_c0:0, exp_d1:0, exp_c1:0};
`else
    vecs[3] = '{kind:3, shift:2, h:1, w:1, exp_len:2, exp_d0:32767, exp_c0:0, exp_d1:-2, exp_c1:1};
    vecs[4] = '{kind:4, shift:40, h:3, w:4, exp_len:1, exp_d0:-1, exp_c0:6, exp_d1:0, exp_c1:0};
`endif

    // Reset state, with a stray i_ready that must do nothing
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_len", o_ia_len, 0);
    check("rst_h", o_ia_h, 0);
    check("rst_w", o_ia_w, 0);
    nz = 0;
    for (int k = 0; k < CHANNEL; k++) if (o_ia_data[k] != 0 || o_ia_c_idx[k] != 0) nz++;
    check("rst_slots", nz, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check("stray_ready_no_valid", o_valid, 0);

    // Directed table, back-to-back at minimum period
    for (int v = 0; v < 5; v++) begin
      build(vecs[v].kind);
      shift_in = vecs[v].shift;
      h_in = 6'(vecs[v].h);
      w_in = 6'(vecs[v].w);
      accept();
      if (v > 0) check("period", acc_cyc - prev_cyc, SCAN + 2);
      prev_cyc = acc_cyc;
      wait_valid(1'b0);
      check("tbl_len", o_ia_len, vecs[v].exp_len);
      check("tbl_d0", longint'(o_ia_data[0]), vecs[v].exp_d0);
      check("tbl_c0", o_ia_c_idx[0], vecs[v].exp_c0);
      check("tbl_d1", longint'(o_ia_data[1]), vecs[v].exp_d1);
      check("tbl_c1", o_ia_c_idx[1], vecs[v].exp_c1);
      check_bundle();
      handshake();
    end

    // Reset asserted mid-scan drops the pixel
    rand_pixel();
    accept();
    repeat (4) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_len", o_ia_len, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    saw = 1'b0;
    i_ready = 1'b1;
    repeat (15) begin
      @(posedge i_clk); #1;
      saw |= o_valid;
    end
    i_ready = 1'b0;
    check("midrst_no_valid", saw, 0);

    // Back-pressure with a competing pixel held on the inputs
    rand_pixel();
    accept();
    wait_valid(1'b0);
    rand_pixel();
    drive_inputs();
    i_valid = 1'b1;
    for (int s = 0; s < 20; s++) begin
      @(posedge i_clk); #1;
      check("hold_stable", (o_valid && !o_ready && o_ia_len == exp_len && o_ia_h == exp_h &&
                            longint'(o_ia_data[0]) == exp_data[0]), 1);
    end
    check_bundle();
    handshake();
    accept();
    check("accept_after_release", acc_cyc - hs_cyc, 1);
    prev_cyc = acc_cyc;
    collect(0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      rand_pixel();
      accept();
      check("b2b_period", acc_cyc - prev_cyc, SCAN + 2);
      prev_cyc = acc_cyc;
      collect(0, 1'b0);
    end

    // Randomized pixels with stalls, idle gaps and stray i_ready during scan
    for (int p = 0; p < 40; p++) begin
      rand_pixel();
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      #1;
      accept();
      collect($urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
